// File: rtl/inst_timing_pkg.sv
// Shared types for the 6502 instruction-length controller: addressing modes,
// access classes, interrupt vector codes and the per-mode cycle table.
package inst_timing_pkg;

  typedef enum logic [3:0] {
    AM_IMP  = 4'd0,
    AM_ACC  = 4'd1,
    AM_IMM  = 4'd2,
    AM_ZP   = 4'd3,
    AM_ZPX  = 4'd4,
    AM_ZPY  = 4'd5,
    AM_ABS  = 4'd6,
    AM_ABSX = 4'd7,
    AM_ABSY = 4'd8,
    AM_INDX = 4'd9,
    AM_INDY = 4'd10,
    AM_IND  = 4'd11,
    AM_REL  = 4'd12
  } addr_mode_e;

  // STACK covers push/pull, JSR/RTS/RTI and BRK; FLOW covers JMP and branches.
  typedef enum logic [2:0] {
    CL_READ  = 3'd0,
    CL_WRITE = 3'd1,
    CL_RMW   = 3'd2,
    CL_STACK = 3'd3,
    CL_FLOW  = 3'd4
  } acc_class_e;

  localparam logic [1:0] VEC_IRQ   = 2'b00;
  localparam logic [1:0] VEC_NMI   = 2'b01;
  localparam logic [1:0] VEC_RESET = 2'b10;
  localparam logic [7:0] OP_BRK    = 8'h00;

  // Index of the final cycle (N-1) before any page-cross / branch extension.
  function automatic logic [2:0] last_step(input addr_mode_e am,
                                           input acc_class_e cls,
                                           input logic [7:0] op);
    logic [2:0] r;
    r = 3'd1;
    case (am)
      AM_IMP, AM_ACC, AM_IMM: begin
        if (cls == CL_STACK) begin
          case (op)
            8'h00:        r = 3'd6;
            8'h08, 8'h48: r = 3'd2;
            8'h28, 8'h68: r = 3'd3;
            default:      r = 3'd5;
          endcase
        end else begin
          r = 3'd1;
        end
      end
      AM_ZP:           r = (cls == CL_RMW) ? 3'd4 : 3'd2;
      AM_ZPX, AM_ZPY:  r = (cls == CL_RMW) ? 3'd5 : 3'd3;
      AM_ABS: begin
        if (cls == CL_STACK || cls == CL_RMW) r = 3'd5;
        else if (cls == CL_FLOW)              r = 3'd2;
        else                                  r = 3'd3;
      end
      AM_ABSX, AM_ABSY: begin
        if (cls == CL_RMW)        r = 3'd6;
        else if (cls == CL_WRITE) r = 3'd4;
        else                      r = 3'd3;
      end
      AM_INDX: r = 3'd5;
      AM_INDY: r = (cls == CL_WRITE) ? 3'd5 : 3'd4;
      AM_IND:  r = 3'd4;
      AM_REL:  r = 3'd1;
      default: r = 3'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_timing_if.sv
// Sequencer <-> instruction-length controller bundle.
interface inst_timing_if;
  import inst_timing_pkg::*;

  logic [5:0] cycle;
  logic       sync;
  logic [7:0] data_in;
  logic       page_cross;
  logic       branch_tkn;
  logic       i_flag;
  logic       irq_n;
  logic       nmi_n;
  logic       next_sync;
  logic [7:0] opcode;
  addr_mode_e addr_mode;
  logic       int_seq;
  logic [1:0] int_vec;
  logic       illegal;

  modport master (
    output cycle, sync, data_in, page_cross, branch_tkn, i_flag, irq_n, nmi_n,
    input  next_sync, opcode, addr_mode, int_seq, int_vec, illegal
  );

  modport slave (
    input  cycle, sync, data_in, page_cross, branch_tkn, i_flag, irq_n, nmi_n,
    output next_sync, opcode, addr_mode, int_seq, int_vec, illegal
  );
endinterface

// File: rtl/inst_timing_op_decode.sv
// Combinational 6502 opcode decode using the aaa-bbb-cc opcode layout.
module op_decode
  import inst_timing_pkg::*;
(
  input  logic [7:0] opcode_i,
  output addr_mode_e addr_mode_o,
  output acc_class_e acc_class_o,
  output logic       illegal_o
);
  logic [2:0] aaa;
  logic [2:0] bbb;
  logic [1:0] cc;
  addr_mode_e am;
  acc_class_e cls;
  logic       ill;

  assign aaa = opcode_i[7:5];
  assign bbb = opcode_i[4:2];
  assign cc  = opcode_i[1:0];

  // Mode/class per opcode group; undefined opcodes fall back to a plain 2-cycle NOP.
  always_comb begin
    am  = AM_IMP;
    cls = CL_READ;
    ill = 1'b0;
    case (cc)
      2'b01: begin
        cls = (aaa == 3'b100) ? CL_WRITE : CL_READ;
        case (bbb)
          3'b000:  am = AM_INDX;
          3'b001:  am = AM_ZP;
          3'b010:  if (aaa == 3'b100) ill = 1'b1; else am = AM_IMM;
          3'b011:  am = AM_ABS;
          3'b100:  am = AM_INDY;
          3'b101:  am = AM_ZPX;
          3'b110:  am = AM_ABSY;
          default: am = AM_ABSX;
        endcase
      end
      2'b10: begin
        cls = (aaa == 3'b100) ? CL_WRITE : (aaa == 3'b101) ? CL_READ : CL_RMW;
        case (bbb)
          3'b000:  if (aaa == 3'b101) am = AM_IMM; else ill = 1'b1;
          3'b001:  am = AM_ZP;
          3'b010:  if (!aaa[2]) am = AM_ACC; else cls = CL_READ;
          3'b011:  am = AM_ABS;
          3'b100:  ill = 1'b1;
          3'b101:  am = (aaa == 3'b100 || aaa == 3'b101) ? AM_ZPY : AM_ZPX;
          3'b110:  if (aaa == 3'b100 || aaa == 3'b101) cls = CL_READ; else ill = 1'b1;
          default: begin
            if (aaa == 3'b100)      ill = 1'b1;
            else if (aaa == 3'b101) am = AM_ABSY;
            else                    am = AM_ABSX;
          end
        endcase
      end
      2'b00: begin
        case (bbb)
          3'b000: begin
            case (aaa)
              3'b000, 3'b010, 3'b011: cls = CL_STACK;
              3'b001:  begin am = AM_ABS; cls = CL_STACK; end
              3'b100:  ill = 1'b1;
              default: am = AM_IMM;
            endcase
          end
          3'b001: begin
            if (aaa == 3'b000 || aaa == 3'b010 || aaa == 3'b011) ill = 1'b1;
            else begin
              am  = AM_ZP;
              cls = (aaa == 3'b100) ? CL_WRITE : CL_READ;
            end
          end
          3'b010:  if (!aaa[2]) cls = CL_STACK;
          3'b011: begin
            case (aaa)
              3'b000:  ill = 1'b1;
              3'b010:  begin am = AM_ABS; cls = CL_FLOW; end
              3'b011:  begin am = AM_IND; cls = CL_FLOW; end
              3'b100:  begin am = AM_ABS; cls = CL_WRITE; end
              default: am = AM_ABS;
            endcase
          end
          3'b100:  begin am = AM_REL; cls = CL_FLOW; end
          3'b101: begin
            if (aaa == 3'b100)      begin am = AM_ZPX; cls = CL_WRITE; end
            else if (aaa == 3'b101) am = AM_ZPX;
            else                    ill = 1'b1;
          end
          3'b110:  am = AM_IMP;
          default: if (aaa == 3'b101) am = AM_ABSX; else ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      am  = AM_IMP;
      cls = CL_READ;
    end
  end

  assign addr_mode_o = am;
  assign acc_class_o = cls;
  assign illegal_o   = ill;
endmodule

// File: rtl/inst_timing.sv
// Instruction-length controller: latches opcodes, signals the last cycle of
// each instruction and injects RESET/NMI/IRQ as forced BRK sequences.
module inst_timing
  import inst_timing_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  inst_timing_if.slave bus
);
  logic [7:0] opcode_q, opcode_d;
  logic       t6_flag_q, t6_flag_d;
  logic       nmi_prev_q;
  logic       nmi_pend_q, nmi_pend_d;
  logic       rst_pend_q, rst_pend_d;
  logic       int_seq_q, int_seq_d;
  logic [1:0] int_vec_q, int_vec_d;

  logic [7:0] op_eff;
  addr_mode_e dec_am;
  acc_class_e dec_cls;
  logic       dec_ill;
  logic [2:0] step;
  logic       step_valid;
  logic [2:0] base;
  logic       read_ext;
  logic       ns;
  logic       take_rst, take_nmi, take_irq;

  // An injected sequence always runs as BRK, even before the T0 latch catches up.
  assign op_eff = int_seq_q ? OP_BRK : opcode_q;

  op_decode u_dec (
    .opcode_i    (op_eff),
    .addr_mode_o (dec_am),
    .acc_class_o (dec_cls),
    .illegal_o   (dec_ill)
  );

  // One-hot cycle to step index; all-zero is T6 only when t6_flag marks it.
  always_comb begin
    step       = 3'd0;
    step_valid = 1'b1;
    case (bus.cycle)
      6'b000001: step = 3'd0;
      6'b000010: step = 3'd1;
      6'b000100: step = 3'd2;
      6'b001000: step = 3'd3;
      6'b010000: step = 3'd4;
      6'b100000: step = 3'd5;
      6'b000000: begin step = 3'd6; step_valid = t6_flag_q; end
      default:   step_valid = 1'b0;
    endcase
  end

  // Last-cycle detection, including page-cross and taken-branch extensions.
  always_comb begin
    base     = last_step(dec_am, dec_cls, op_eff);
    read_ext = (dec_cls == CL_READ) &&
               (dec_am == AM_ABSX || dec_am == AM_ABSY || dec_am == AM_INDY);
    ns       = 1'b0;
    if (!rst_n) begin
      ns = 1'b0;
    end else if (rst_pend_q) begin
      ns = (bus.cycle == 6'd0);
    end else if (step_valid) begin
      if (dec_am == AM_REL) begin
        case (step)
          3'd1:    ns = !bus.branch_tkn;
          3'd2:    ns = !bus.page_cross;
          3'd3:    ns = 1'b1;
          default: ns = 1'b0;
        endcase
      end else if (read_ext) begin
        ns = ((step == base) && !bus.page_cross) || (step == base + 3'd1);
      end else begin
        ns = (step == base);
      end
    end
  end

  // Boundary bookkeeping: interrupt acceptance, NMI edge capture, opcode latch.
  always_comb begin
    take_rst   = ns && rst_pend_q;
    take_nmi   = ns && !rst_pend_q && nmi_pend_q;
    take_irq   = ns && !rst_pend_q && !nmi_pend_q && !bus.irq_n && !bus.i_flag;
    rst_pend_d = rst_pend_q && !ns;
    nmi_pend_d = (nmi_pend_q && !take_nmi) || (nmi_prev_q && !bus.nmi_n);
    int_seq_d  = ns ? (take_rst || take_nmi || take_irq) : int_seq_q;
    int_vec_d  = int_vec_q;
    if (take_rst)      int_vec_d = VEC_RESET;
    else if (take_nmi) int_vec_d = VEC_NMI;
    else if (take_irq) int_vec_d = VEC_IRQ;
    opcode_d   = bus.sync ? (int_seq_q ? OP_BRK : bus.data_in) : opcode_q;
    t6_flag_d  = ns ? 1'b0 : (bus.cycle[5] ? 1'b1 : t6_flag_q);
  end

  // State registers with asynchronous reset into the pending RESET sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q   <= 8'h00;
      t6_flag_q  <= 1'b0;
      nmi_prev_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      rst_pend_q <= 1'b1;
      int_seq_q  <= 1'b1;
      int_vec_q  <= VEC_RESET;
    end else begin
      opcode_q   <= opcode_d;
      t6_flag_q  <= t6_flag_d;
      nmi_prev_q <= bus.nmi_n;
      nmi_pend_q <= nmi_pend_d;
      rst_pend_q <= rst_pend_d;
      int_seq_q  <= int_seq_d;
      int_vec_q  <= int_vec_d;
    end
  end

  assign bus.next_sync = ns;
  assign bus.opcode    = op_eff;
  assign bus.addr_mode = dec_am;
  assign bus.int_seq   = int_seq_q;
  assign bus.int_vec   = int_vec_q;
  assign bus.illegal   = dec_ill && bus.cycle[1];
endmodule
